// File: rtl/paddle_btn_ctrl.sv
// Paddle push-button conditioning: per-channel synchronizer, debounce and
// press/hold/auto-repeat FSM producing one-cycle paddle step pulses.
module paddle_btn_ctrl #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HOLD_DELAY      = 5000000,
    parameter int unsigned REPEAT_PERIOD   = 100000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_dwn_i,
    input  logic btn_up_i,
    output logic dwn_level_o,
    output logic up_level_o,
    output logic step_dwn_o,
    output logic step_up_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0] btn_raw;
    logic [1:0] lvl_q;
    logic [1:0] lvl_next;
    logic [1:0] raw_step;

    assign btn_raw = {btn_up_i, btn_dwn_i};

    // Channel 0 is down, channel 1 is up.
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   lvl_r;
        logic                   lvl_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic [CNT_W-1:0]       tmr_q;
        logic [CNT_W-1:0]       tmr_d;
        logic [1:0]             state_q;
        logic [1:0]             state_d;
        logic                   step_c;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                sync_q  <= '0;
                lvl_r   <= 1'b0;
                cnt_q   <= '0;
                tmr_q   <= '0;
                state_q <= ST_IDLE;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw[c]};
                lvl_r   <= lvl_d;
                cnt_q   <= cnt_d;
                tmr_q   <= tmr_d;
                state_q <= state_d;
            end
        end

        // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
        always_comb begin
            lvl_d = lvl_r;
            cnt_d = '0;
            if (sync_q[SYNC_STAGES-1] != lvl_r) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d = ~lvl_r;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Decisions use the next level so steps line up with level_o.
        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            step_c  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lvl_d) begin
                        step_c  = 1'b1;
                        tmr_d   = '0;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!lvl_d) begin
                        tmr_d   = '0;
                        state_d = ST_IDLE;
                    end else if (tmr_q == CNT_W'(HOLD_DELAY - 1)) begin
                        step_c  = 1'b1;
                        tmr_d   = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!lvl_d) begin
                        tmr_d   = '0;
                        state_d = ST_IDLE;
                    end else if (tmr_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                        step_c = 1'b1;
                        tmr_d  = '0;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
                default: begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        assign lvl_q[c]    = lvl_r;
        assign lvl_next[c] = lvl_d;
        assign raw_step[c] = step_c;
    end

    // A channel's steps are suppressed while the opposite button is held.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            step_dwn_o <= 1'b0;
            step_up_o  <= 1'b0;
        end else begin
            step_dwn_o <= raw_step[0] & ~lvl_next[1];
            step_up_o  <= raw_step[1] & ~lvl_next[0];
        end
    end

    assign dwn_level_o = lvl_q[0];
    assign up_level_o  = lvl_q[1];

endmodule
